param_dff_register: RTL and testbench
=====================================

// Module: param_dff_register
// PURPOSE
//   Parametrised multi-bit successor to the single-bit D flip-flop.
//   WIDTH-bit register on one clock with synchronous reset and clock enable.
//   An 8-way mode select gives hold, parallel load, shift left/right,
//   increment, decrement, clear and set.
//   Building block for the counter and shift-register experiments that follow the latch labs.
// PARAMETERS
//   WIDTH  8      register width in bits; legal range WIDTH >= 2
//   INIT   8'h00  value loaded into Q on reset; only INIT[WIDTH-1:0] is used
// PORTS
//   C     input   1      clock; all state changes on rising edge
//   R     input   1      reset; synchronous, active-high
//   CE    input   1      clock enable; active-high
//   M     input   3      mode select (see BEHAVIOUR)
//   D     input   WIDTH  parallel load data
//   SL    input   1      serial in for shift-left; enters at Q[0]
//   SR    input   1      serial in for shift-right; enters at Q[WIDTH-1]
//   Q     output  WIDTH  register state
//   Qbar  output  WIDTH  bitwise complement of Q
//   TC    output  1      terminal count flag (combinational)
// BEHAVIOUR
//   - One clock (C). Reset R is synchronous and active-high.
//   - Priority on each rising edge of C: R, then CE, then M.
//   - R=1: Q <= INIT[WIDTH-1:0]. This applies regardless of CE and M.
//     Qbar = ~INIT and TC follows its rule from the first cycle out of reset.
//   - R=0, CE=0: Q holds. M, D, SL and SR are ignored.
//   - R=0, CE=1: one-cycle latency; the new Q is visible right after the edge.
//       M=000 HOLD  Q <= Q
//       M=001 LOAD  Q <= D
//       M=010 SHL   Q <= {Q[WIDTH-2:0], SL}
//       M=011 SHR   Q <= {SR, Q[WIDTH-1:1]}
//       M=100 INC   Q <= Q + 1, modulo 2^WIDTH (all ones wraps to 0)
//       M=101 DEC   Q <= Q - 1, modulo 2^WIDTH (0 wraps to all ones)
//       M=110 CLR   Q <= 0
//       M=111 SET   Q <= all ones
//   - Qbar = ~Q at all times, including during reset. No independent state.
//   - TC (combinational from Q, M and CE; does not depend on R):
//       1 when CE=1, M=INC and Q = all ones
//       1 when CE=1, M=DEC and Q = 0
//       0 otherwise
//     TC is therefore 1 in exactly the cycle before a wrap; external cascading uses this.
//   - Reset mid-operation: R overrides any mode on the same edge.
//     Nothing of the pending operation is retained.
//   - X or Z on M with CE=1 must not be silently accepted: Q <= Q.
//     A simulation-only $display warning is permitted.
// CONFIGURATION
//   ROTATE_EN
//     defined:   SHL is Q <= {Q[WIDTH-2:0], Q[WIDTH-1]} and SHR is
//                Q <= {Q[0], Q[WIDTH-1:1]}; SL and SR are ignored.
//     undefined: SHL and SHR use SL and SR exactly as listed above.
//     Every other mode is identical in both builds.
// TESTING  (WIDTH=8, INIT=8'h00, C period 100 ns)
//   1. R=1 for 2 edges, any M/D -> Q=8'h00, Qbar=8'hFF, TC=0.
//      Release R with CE=0 and M=001, D=8'hA5 -> Q stays 8'h00.
//   2. CE=1, M=001, D=8'hA5, one edge -> Q=8'hA5, Qbar=8'h5A.
//      Then M=000 for 3 edges -> Q stays 8'hA5.
//   3. From Q=8'hA5, M=010, SL=1, one edge -> Q=8'h4B.
//      Then M=011, SR=0 -> Q=8'h25.
//      With ROTATE_EN: SHL from 8'hA5 -> 8'h4B; SHR from 8'hA5 -> 8'hD2.
//   4. Load 8'hFE, M=100 -> TC=0, edge -> Q=8'hFF and TC=1, edge -> Q=8'h00 and TC=0.
//      Then M=101 -> TC=1, edge -> Q=8'hFF.
//   5. M=111 then M=110 -> Q=8'hFF then 8'h00.
//      R=1 together with CE=1, M=001, D=8'h3C -> Q=8'h00 (reset wins).
//   6. CE=0 with M=100 and Q=8'hFF -> TC=0 and Q holds 8'hFF.
//      Then CE=1 -> TC=1 and the next edge wraps Q to 8'h00.

Source files
------------

// File: rtl/param_dff_register.sv
// param_dff_register
//   WIDTH-bit register with synchronous active-high reset, clock enable and
//   an 8-way mode select (hold, load, shift left/right, increment,
//   decrement, clear, set). Qbar is the bitwise complement of Q. TC flags
//   the cycle before an increment or decrement wraps.
//
//   Optional build macro: ROTATE_EN
//     defined   - SHL/SHR rotate Q and ignore SL/SR
//     undefined - SHL/SHR shift in SL/SR
module param_dff_register #(
    parameter int              WIDTH = 8,
    // Only the low WIDTH bits of the reset value are meaningful.
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic [2:0]       M,
    input  logic [WIDTH-1:0] D,
    input  logic             SL,
    input  logic             SR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             TC
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_INC  = 3'b100,
        MODE_DEC  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_SET  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             tc;

`ifdef ROTATE_EN
    // Serial inputs have no role when shifts rotate.
    logic unused_serial;
    assign unused_serial = SL ^ SR;

    // Rotating shifts feed the bit that falls off back into the other end.
    always_comb begin
        shl_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shr_val = {q_q[0], q_q[WIDTH-1:1]};
    end
`else
    // Plain shifts take the new end bit from the serial inputs.
    always_comb begin
        shl_val = {q_q[WIDTH-2:0], SL};
        shr_val = {SR, q_q[WIDTH-1:1]};
    end
`endif

    // Next-state selection; an unrecognised (X/Z) mode falls to hold.
    always_comb begin
        q_d = q_q;
        if (CE) begin
            case (M)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = D;
                MODE_SHL:  q_d = shl_val;
                MODE_SHR:  q_d = shr_val;
                MODE_INC:  q_d = q_q + ONE;
                MODE_DEC:  q_d = q_q - ONE;
                MODE_CLR:  q_d = ALL_ZERO;
                MODE_SET:  q_d = ALL_ONES;
                default:   q_d = q_q;
            endcase
        end
    end

    // State register; reset wins over enable and mode on the same edge.
    always_ff @(posedge C) begin
        if (R) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal count: high only in the cycle whose edge will wrap Q.
    always_comb begin
        tc = 1'b0;
        if (CE) begin
            case (M)
                MODE_INC: tc = (q_q == ALL_ONES);
                MODE_DEC: tc = (q_q == ALL_ZERO);
                default:  tc = 1'b0;
            endcase
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;
    assign TC   = tc;

endmodule

// File: tb/tb_param_dff_register.sv
// Testbench for param_dff_register (WIDTH=8, INIT=8'h00).
// Table of directed vectors followed by a few multi-cycle sequences.
module tb_param_dff_register;

    logic       clk_c;
    logic       r;
    logic       ce;
    logic [2:0] m;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       tc;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        string      name;
        logic       r;
        logic       ce;
        logic [2:0] m;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic       exp_tc;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[$];

`ifdef ROTATE_EN
    localparam logic [7:0] EXP_SHR_FROM_4B = 8'hA5;
    localparam logic [7:0] EXP_SHL_FROM_D2 = 8'hA5;
    localparam bit         ROT             = 1'b1;
`else
    localparam logic [7:0] EXP_SHR_FROM_4B = 8'h25;
    localparam logic [7:0] EXP_SHL_FROM_D2 = 8'hA4;
    localparam bit         ROT             = 1'b0;
`endif

    param_dff_register #(
        .WIDTH(8),
        .INIT (8'h00)
    ) dut (
        .C   (clk_c),
        .R   (r),
        .CE  (ce),
        .M   (m),
        .D   (d),
        .SL  (sl),
        .SR  (sr),
        .Q   (q),
        .Qbar(qbar),
        .TC  (tc)
    );

    // 100 ns clock period
    initial begin
        clk_c = 1'b0;
        forever #50 clk_c = ~clk_c;
    end

    // Drive one set of inputs shortly after the falling edge.
    task automatic applyStimulus(input logic v_r, input logic v_ce, input logic [2:0] v_m,
                                 input logic [7:0] v_d, input logic v_sl, input logic v_sr);
        @(negedge clk_c);
        r  = v_r;
        ce = v_ce;
        m  = v_m;
        d  = v_d;
        sl = v_sl;
        sr = v_sr;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Check TC before the edge, then Q and Qbar just after it.
    task automatic runCycle(input string name, input logic exp_tc, input logic [7:0] exp_q);
        #1;
        checkOutput({name, " TC"}, {7'b0, tc}, {7'b0, exp_tc});
        @(posedge clk_c);
        #1;
        checkOutput({name, " Q"}, q, exp_q);
        checkOutput({name, " Qbar"}, qbar, ~exp_q);
    endtask

    function automatic void addVec(input string name, input logic v_r, input logic v_ce,
                                   input logic [2:0] v_m, input logic [7:0] v_d,
                                   input logic v_sl, input logic v_sr,
                                   input logic exp_tc, input logic [7:0] exp_q);
        vec_t v;
        v.name = name; v.r = v_r; v.ce = v_ce; v.m = v_m; v.d = v_d;
        v.sl = v_sl; v.sr = v_sr; v.exp_tc = exp_tc; v.exp_q = exp_q;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] exp_q;

        r = 1'b1; ce = 1'b0; m = 3'b000; d = 8'h00; sl = 1'b0; sr = 1'b0;

        //      name            r  ce  m       d      sl sr  tc  q
        addVec("reset1",       1, 0, 3'b001, 8'hA5, 0, 0, 0, 8'h00);
        addVec("reset2",       1, 1, 3'b100, 8'h00, 0, 0, 0, 8'h00);
        addVec("ce0_load",     0, 0, 3'b001, 8'hA5, 0, 0, 0, 8'h00);
        addVec("load_a5",      0, 1, 3'b001, 8'hA5, 0, 0, 0, 8'hA5);
        addVec("hold1",        0, 1, 3'b000, 8'h00, 1, 1, 0, 8'hA5);
        addVec("hold2",        0, 1, 3'b000, 8'hFF, 0, 1, 0, 8'hA5);
        addVec("hold3",        0, 1, 3'b000, 8'h3C, 1, 0, 0, 8'hA5);
        addVec("shl_sl1",      0, 1, 3'b010, 8'h00, 1, 0, 0, 8'h4B);
        addVec("shr_sr0",      0, 1, 3'b011, 8'h00, 1, 0, 0, EXP_SHR_FROM_4B);
        addVec("reload_a5",    0, 1, 3'b001, 8'hA5, 0, 0, 0, 8'hA5);
        addVec("shr_sr1",      0, 1, 3'b011, 8'h00, 0, 1, 0, 8'hD2);
        addVec("shl_sl0",      0, 1, 3'b010, 8'h00, 0, 1, 0, EXP_SHL_FROM_D2);
        addVec("load_fe",      0, 1, 3'b001, 8'hFE, 0, 0, 0, 8'hFE);
        addVec("inc_fe",       0, 1, 3'b100, 8'h00, 0, 0, 0, 8'hFF);
        addVec("inc_wrap",     0, 1, 3'b100, 8'h00, 0, 0, 1, 8'h00);
        addVec("dec_wrap",     0, 1, 3'b101, 8'h00, 0, 0, 1, 8'hFF);
        addVec("dec_ff",       0, 1, 3'b101, 8'h00, 0, 0, 0, 8'hFE);
        addVec("set",          0, 1, 3'b111, 8'h00, 0, 0, 0, 8'hFF);
        addVec("clr",          0, 1, 3'b110, 8'hFF, 1, 1, 0, 8'h00);
        addVec("load_77",      0, 1, 3'b001, 8'h77, 0, 0, 0, 8'h77);
        addVec("reset_wins",   1, 1, 3'b001, 8'h3C, 0, 0, 0, 8'h00);
        addVec("load_ff",      0, 1, 3'b001, 8'hFF, 0, 0, 0, 8'hFF);
        addVec("ce0_inc",      0, 0, 3'b100, 8'h00, 0, 0, 0, 8'hFF);
        addVec("ce1_inc_wrap", 0, 1, 3'b100, 8'h00, 0, 0, 1, 8'h00);
        addVec("load_ff2",     0, 1, 3'b001, 8'hFF, 0, 0, 0, 8'hFF);
        addVec("reset_tc",     1, 1, 3'b100, 8'h00, 0, 0, 1, 8'h00);
        addVec("reset_set",    1, 0, 3'b111, 8'hFF, 1, 1, 0, 8'h00);
        addVec("ce0_dec_zero", 0, 0, 3'b101, 8'h00, 0, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].ce, vecs[i].m, vecs[i].d, vecs[i].sl, vecs[i].sr);
            runCycle(vecs[i].name, vecs[i].exp_tc, vecs[i].exp_q);
        end

        // Unknown mode with CE=1 must leave Q unchanged.
        applyStimulus(0, 1, 3'b001, 8'h5A, 0, 0);
        runCycle("load_5a", 1'b0, 8'h5A);
        applyStimulus(0, 1, 3'bxxx, 8'hC3, 1, 1);
        runCycle("mode_x", 1'b0, 8'h5A);

        // Walk a single one leftwards through every bit position.
        applyStimulus(0, 1, 3'b001, 8'h01, 0, 0);
        runCycle("load_01", 1'b0, 8'h01);
        exp_q = 8'h01;
        for (int i = 0; i < 8; i++) begin
            exp_q = ROT ? {exp_q[6:0], exp_q[7]} : {exp_q[6:0], 1'b0};
            applyStimulus(0, 1, 3'b010, 8'h00, 0, 0);
            runCycle($sformatf("walk%0d", i), 1'b0, exp_q);
        end

        // Full increment sweep; TC must rise only at all ones.
        applyStimulus(0, 1, 3'b110, 8'h00, 0, 0);
        runCycle("sweep_clr", 1'b0, 8'h00);
        exp_q = 8'h00;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 1, 3'b100, 8'h00, 0, 0);
            runCycle($sformatf("sweep%0d", i), (exp_q == 8'hFF), exp_q + 8'h01);
            exp_q = exp_q + 8'h01;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
